// File: rtl/decoder_seq.sv
// Sequenced one-hot decoder: direct code load or timed scan from code 1 up to a captured last code.
// Optional macro DECODER_SEQ_WRAP_EN adds a wrap input so a scan loops until aborted.
module decoder_seq #(
   parameter int SEL_W = 4,
   parameter int DWELL = 1,
   localparam int N = 2**SEL_W - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SEL_W-1:0] in_sig,
   input  logic             start,
   input  logic             abort,
`ifdef DECODER_SEQ_WRAP_EN
   input  logic             wrap,
`endif
   input  logic [SEL_W-1:0] last_code,
   output logic [N-1:0]     out_sig,
   output logic [SEL_W-1:0] cur_code,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [7:0] DWELL_INIT = 8'(DWELL - 1);

   state_t           state_q, state_d;
   logic [SEL_W-1:0] cur_code_q, cur_code_d;
   logic [N-1:0]     out_sig_q, out_sig_d;
   logic [7:0]       dwell_q, dwell_d;
   logic [SEL_W-1:0] last_q, last_d;
   logic             wrap_q, wrap_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wrap_in;

`ifdef DECODER_SEQ_WRAP_EN
   assign wrap_in = wrap;
`else
   assign wrap_in = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cur_code_d = cur_code_q;
      dwell_d    = dwell_q;
      last_d     = last_q;
      wrap_d     = wrap_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               last_d = last_code;
               wrap_d = wrap_in;
               if (last_code == '0) begin
                  state_d    = FIN;
                  cur_code_d = '0;
               end else begin
                  state_d    = SCAN;
                  cur_code_d = SEL_W'(1);
                  dwell_d    = DWELL_INIT;
               end
            end else if (load) begin
               cur_code_d = in_sig;
            end
         end
         SCAN: begin
            // Abort wins over the dwell countdown and the code step.
            if (abort) begin
               state_d    = IDLE;
               cur_code_d = '0;
               dwell_d    = '0;
            end else if (dwell_q != 8'd0) begin
               dwell_d = dwell_q - 8'd1;
            end else if (cur_code_q == last_q) begin
               if (wrap_q) begin
                  cur_code_d = SEL_W'(1);
                  dwell_d    = DWELL_INIT;
               end else begin
                  state_d    = FIN;
                  cur_code_d = '0;
               end
            end else begin
               cur_code_d = cur_code_q + SEL_W'(1);
               dwell_d    = DWELL_INIT;
            end
         end
         FIN: begin
            state_d    = IDLE;
            cur_code_d = '0;
         end
         default: begin
            state_d    = IDLE;
            cur_code_d = '0;
            dwell_d    = '0;
         end
      endcase
   end

   // Outputs are decoded from next-state values so they register alongside cur_code.
   always_comb begin
      out_sig_d = '0;
      for (int i = 0; i < N; i++) begin
         out_sig_d[i] = (cur_code_d == SEL_W'(i + 1));
      end
      busy_d = (state_d == SCAN);
      done_d = (state_d == FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cur_code_q <= '0;
         out_sig_q  <= '0;
         dwell_q    <= '0;
         last_q     <= '0;
         wrap_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_code_q <= cur_code_d;
         out_sig_q  <= out_sig_d;
         dwell_q    <= dwell_d;
         last_q     <= last_d;
         wrap_q     <= wrap_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign out_sig  = out_sig_q;
   assign cur_code = cur_code_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: a DWELL=1 and a DWELL=2 instance share all inputs.
module tb_decoder_seq;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [3:0]  in_sig;
   logic        start;
   logic        abort;
   logic        wrap;
   logic [3:0]  last_code;
   logic [14:0] out1, out2;
   logic [3:0]  cur1, cur2;
   logic        busy1, busy2;
   logic        done1, done2;

   int n_pass;
   int n_total;

   decoder_seq #(.SEL_W(4), .DWELL(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .in_sig    (in_sig),
      .start     (start),
      .abort     (abort),
`ifdef DECODER_SEQ_WRAP_EN
      .wrap      (wrap),
`endif
      .last_code (last_code),
      .out_sig   (out1),
      .cur_code  (cur1),
      .busy      (busy1),
      .done      (done1)
   );

   decoder_seq #(.SEL_W(4), .DWELL(2)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .in_sig    (in_sig),
      .start     (start),
      .abort     (abort),
`ifdef DECODER_SEQ_WRAP_EN
      .wrap      (wrap),
`endif
      .last_code (last_code),
      .out_sig   (out2),
      .cur_code  (cur2),
      .busy      (busy2),
      .done      (done2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        load;
      logic [3:0]  in_sig;
      logic        start;
      logic [3:0]  last;
      logic [3:0]  cur;
      logic [14:0] out;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      load = 1'b0; start = 1'b0; abort = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   initial begin
      n_pass = 0; n_total = 0;
      rst_n = 1'b0; load = 1'b0; in_sig = '0; start = 1'b0;
      abort = 1'b0; wrap = 1'b0; last_code = '0;

      #2;
      chk("rst_cur", 32'(cur1), 0);
      chk("rst_out", 32'(out1), 0);
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_done", 32'(done2), 0);
      step(); step();
      rst_n = 1'b1;
      step();

      // DWELL=1 instance, one row per clock
      vecs[0]  = '{1'b1, 4'd5,  1'b0, 4'd0, 4'd5,  15'h0010, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'd1,  1'b0, 4'd0, 4'd1,  15'h0001, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 4'd15, 1'b0, 4'd0, 4'd15, 15'h4000, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 4'd3,  1'b0, 4'd0, 4'd15, 15'h4000, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 4'd0,  1'b0, 4'd0, 4'd0,  15'h0000, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 4'd9,  1'b1, 4'd2, 4'd1,  15'h0001, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 4'd9,  1'b1, 4'd2, 4'd2,  15'h0002, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 4'd0,  1'b0, 4'd0, 4'd0,  15'h0000, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 4'd7,  1'b0, 4'd0, 4'd0,  15'h0000, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 4'd7,  1'b0, 4'd0, 4'd7,  15'h0040, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 4'd0,  1'b1, 4'd0, 4'd0,  15'h0000, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 4'd0,  1'b0, 4'd0, 4'd0,  15'h0000, 1'b0, 1'b0};

      for (int i = 0; i < 12; i++) begin
         load = vecs[i].load; in_sig = vecs[i].in_sig;
         start = vecs[i].start; last_code = vecs[i].last;
         step();
         chk($sformatf("vec%0d_cur", i), 32'(cur1), 32'(vecs[i].cur));
         chk($sformatf("vec%0d_out", i), 32'(out1), 32'(vecs[i].out));
         chk($sformatf("vec%0d_busy", i), 32'(busy1), 32'(vecs[i].busy));
         chk($sformatf("vec%0d_done", i), 32'(done1), 32'(vecs[i].done));
      end
      idle(40);

      // DWELL=2, last_code=3
      start = 1'b1; last_code = 4'd3;
      step();
      start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         logic [14:0] e;
         e = 15'(1) << (k / 2);
         chk($sformatf("d2_out%0d", k), 32'(out2), 32'(e));
         chk($sformatf("d2_busy%0d", k), 32'(busy2), 1);
         chk($sformatf("d2_done%0d", k), 32'(done2), 0);
         step();
      end
      chk("d2_fin_done", 32'(done2), 1);
      chk("d2_fin_out", 32'(out2), 0);
      chk("d2_fin_busy", 32'(busy2), 0);
      step();
      chk("d2_after_done", 32'(done2), 0);
      idle(40);

      // DWELL=1, full walk to last_code=15
      start = 1'b1; last_code = 4'd15;
      step();
      start = 1'b0;
      for (int k = 0; k < 15; k++) begin
         logic [14:0] e;
         e = 15'(1) << k;
         chk($sformatf("walk_out%0d", k), 32'(out1), 32'(e));
         chk($sformatf("walk_busy%0d", k), 32'(busy1), 1);
         step();
      end
      chk("walk_done", 32'(done1), 1);
      chk("walk_fin_out", 32'(out1), 0);
      step();
      chk("walk_done_clr", 32'(done1), 0);
      start = 1'b1; last_code = 4'd0;
      step();
      start = 1'b0;
      chk("zero_done", 32'(done1), 1);
      chk("zero_out", 32'(out1), 0);
      chk("zero_busy", 32'(busy1), 0);
      step();
      chk("zero_done_clr", 32'(done1), 0);
      chk("zero_out2", 32'(out1), 0);
      idle(40);

      // abort during code 2 of a last_code=6 scan
      start = 1'b1; last_code = 4'd6;
      step();
      start = 1'b0;
      chk("ab_code1", 32'(cur1), 1);
      step();
      chk("ab_code2", 32'(cur1), 2);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_cur", 32'(cur1), 0);
      chk("ab_out", 32'(out1), 0);
      chk("ab_busy", 32'(busy1), 0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("ab_nodone%0d", k), 32'(done1), 0);
         step();
      end
      idle(40);

      // asynchronous reset mid-scan
      start = 1'b1; last_code = 4'd6;
      step();
      start = 1'b0;
      step();
      chk("rs_pre_cur", 32'(cur1), 2);
      #2 rst_n = 1'b0;
      #1;
      chk("rs_cur", 32'(cur1), 0);
      chk("rs_out", 32'(out1), 0);
      chk("rs_busy", 32'(busy1), 0);
      chk("rs_out2", 32'(out2), 0);
      step();
      chk("rs_held_done", 32'(done1), 0);
      rst_n = 1'b1;
      step();
      start = 1'b1; last_code = 4'd2;
      step();
      start = 1'b0;
      chk("rs_restart_cur", 32'(cur1), 1);
      chk("rs_restart_out", 32'(out1), 15'h0001);
      chk("rs_restart_busy", 32'(busy1), 1);
      idle(40);

`ifdef DECODER_SEQ_WRAP_EN
      // wrap loops 1,2,1,2 until abort
      wrap = 1'b1; start = 1'b1; last_code = 4'd2;
      step();
      start = 1'b0; wrap = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("wr_cur%0d", k), 32'(cur1), 32'((k % 2) + 1));
         chk($sformatf("wr_nodone%0d", k), 32'(done1), 0);
         step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("wr_ab_cur", 32'(cur1), 0);
      chk("wr_ab_busy", 32'(busy1), 0);
      chk("wr_ab_done", 32'(done1), 0);
      idle(4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
